// File: rtl/rx_fifo_buffer_pkg.sv
// -----------------------------------------------------------------------------
// rx_fifo_buffer_pkg
// Shared constants for the receive FIFO: default geometry, the default
// almost-empty / almost-full thresholds and the link idle code, plus a helper
// that sizes the FIFO pointers.
// -----------------------------------------------------------------------------
package rx_fifo_buffer_pkg;

   localparam int          DATA_W_DEFAULT = 8;
   localparam int          DEPTH_DEFAULT  = 8;
   localparam int          AE_TH_DEFAULT  = 2;
   localparam int          AF_TH_DEFAULT  = 6;

   // K28.5-style comma/idle byte; the deserializer clears valid_in for it.
   localparam logic [7:0]  IDLE_CODE      = 8'hBC;

   // Pointer width for a power-of-two depth (at least 1 bit).
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rx_fifo_buffer_fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_W storage with one synchronous write port and one synchronous,
// registered read port. The read register is the FIFO's data_out; it only
// loads on i_rd_en so it holds its value between reads.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    synchronous active-low reset, clears the read register only
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read strobe (loads o_rd_data on the next edge)
//   i_rd_addr  read address
//   o_rd_data  registered read data
// -----------------------------------------------------------------------------
module fifo_mem
   import rx_fifo_buffer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DEPTH  = DEPTH_DEFAULT
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_wr_en,
   input  logic [ptr_width(DEPTH)-1:0]   i_wr_addr,
   input  logic [DATA_W-1:0]             i_wr_data,
   input  logic                          i_rd_en,
   input  logic [ptr_width(DEPTH)-1:0]   i_rd_addr,
   output logic [DATA_W-1:0]             o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read-before-write: when full with a simultaneous push and pop, both
   // addresses are equal and the read must return the old entry.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rd_data <= '0;
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_fifo_buffer.sv
// -----------------------------------------------------------------------------
// rx_fifo_buffer
// Receive-side byte FIFO between the deserializer and the consumer. Bytes are
// written while the link is aligned and a payload byte is present; the
// consumer pops with one cycle of read latency. Status flags come from the
// registered occupancy count. A dropped byte sets a sticky overflow flag.
//
// Ports
//   clk_4f        parallel-byte clock, rising edge
//   reset         synchronous active-low reset
//   data_in       received byte
//   valid_in      data_in is payload (not idle)
//   active_in     link aligned; gates writes
//   pop           consumer read request
//   data_out      registered read data, holds when valid_out=0
//   valid_out     data_out was read by the previous accepted pop
//   fifo_empty    count == 0
//   fifo_full     count == DEPTH
//   almost_empty  count <= AE_TH
//   almost_full   count >= AF_TH
//   overflow_err  sticky: a byte was dropped while full
// -----------------------------------------------------------------------------
module rx_fifo_buffer
   import rx_fifo_buffer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int AE_TH  = AE_TH_DEFAULT,
   parameter int AF_TH  = AF_TH_DEFAULT
) (
   input  logic              clk_4f,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   input  logic              active_in,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              overflow_err
);

   localparam int                PTR_W  = ptr_width(DEPTH);
   localparam int                CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  AE_C   = CNT_W'(AE_TH);
   localparam logic [CNT_W-1:0]  AF_C   = CNT_W'(AF_TH);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_valid_out;
   logic             r_overflow;

   logic             w_wr_req;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   // Reset cycles swallow both requests so storage is never written in reset.
   assign w_wr_req = valid_in && active_in && reset;
   assign w_pop    = pop && !fifo_empty && reset;
   // When full, a write is still accepted if a pop frees a slot this cycle.
   // No fall-through on empty: w_pop is already 0 there.
   assign w_push   = w_wr_req && (!fifo_full || w_pop);
   assign w_drop   = w_wr_req && fifo_full && !w_pop;

   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_valid_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         r_valid_out <= w_pop;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .i_clk     (clk_4f),
      .i_rst_n   (reset),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (data_in),
      .i_rd_en   (w_pop),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (data_out)
   );

   assign valid_out    = r_valid_out;
   assign overflow_err = r_overflow;
   assign fifo_empty   = (r_count == '0);
   assign fifo_full    = (r_count == FULL_C);
   assign almost_empty = (r_count <= AE_C);
   assign almost_full  = (r_count >= AF_C);

endmodule

// File: tb/tb_rx_fifo_buffer.sv
// -----------------------------------------------------------------------------
// tb_rx_fifo_buffer
// Directed scenarios followed by randomized traffic. A queue-based reference
// model predicts each accepted pop and pushes the expected byte into a
// scoreboard; a monitor on the falling edge pops the scoreboard whenever
// valid_out is seen and also checks every status flag against the model.
// -----------------------------------------------------------------------------
module tb_rx_fifo_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AE_TH = 2;
   localparam int AF_TH = 6;

   logic          clk_4f = 1'b0;
   logic          reset;
   logic [DW-1:0] data_in;
   logic          valid_in;
   logic          active_in;
   logic          pop;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          fifo_empty;
   logic          fifo_full;
   logic          almost_empty;
   logic          almost_full;
   logic          overflow_err;

   rx_fifo_buffer #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .AE_TH  (AE_TH),
      .AF_TH  (AF_TH)
   ) dut (
      .clk_4f       (clk_4f),
      .reset        (reset),
      .data_in      (data_in),
      .valid_in     (valid_in),
      .active_in    (active_in),
      .pop          (pop),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .overflow_err (overflow_err)
   );

   always #5 clk_4f = ~clk_4f;

   // Reference model state
   logic [DW-1:0] mq[$];   // bytes currently stored
   logic [DW-1:0] sb[$];   // scoreboard: bytes expected on valid_out
   logic          m_vld;
   logic          m_ovf;
   logic [DW-1:0] m_last;
   bit            mon_en = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model of one clock edge, from the FIFO's rules.
   task automatic model_edge(input logic rn, input logic v, input logic a,
                             input logic p, input logic [DW-1:0] d);
      bit pa;
      bit wa;
      if (!rn) begin
         mq.delete();
         sb.delete();
         m_ovf  = 1'b0;
         m_vld  = 1'b0;
         m_last = '0;
      end else begin
         pa = p && (mq.size() > 0);
         wa = v && a && ((mq.size() < DEPTH) || pa);
         m_vld = pa;
         if (pa) begin
            m_last = mq.pop_front();
            sb.push_back(m_last);
         end
         if (wa) mq.push_back(d);
         else if (v && a) m_ovf = 1'b1;
      end
   endtask

   task automatic cyc(input logic rn, input logic v, input logic a,
                      input logic p, input logic [DW-1:0] d);
      reset     = rn;
      valid_in  = v;
      active_in = a;
      pop       = p;
      data_in   = d;
      @(posedge clk_4f);
      model_edge(rn, v, a, p, d);
      @(negedge clk_4f);
   endtask

   task automatic push_b(input logic [DW-1:0] d); cyc(1'b1, 1'b1, 1'b1, 1'b0, d);     endtask
   task automatic pop_b();                        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hBC); endtask
   task automatic both_b(input logic [DW-1:0] d); cyc(1'b1, 1'b1, 1'b1, 1'b1, d);     endtask
   task automatic idle_b();                       cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hBC); endtask
   task automatic rst_b();                        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hBC); endtask

   // Monitor: consumes the scoreboard whenever the DUT presents a byte.
   always @(negedge clk_4f) begin
      if (mon_en) begin
         chk("valid_out", valid_out, m_vld);
         if (valid_out && sb.size() > 0) chk("data_out", data_out, sb.pop_front());
         else                            chk("data_hold", data_out, m_last);
         chk("fifo_empty",   fifo_empty,   mq.size() == 0);
         chk("fifo_full",    fifo_full,    mq.size() == DEPTH);
         chk("almost_empty", almost_empty, mq.size() <= AE_TH);
         chk("almost_full",  almost_full,  mq.size() >= AF_TH);
         chk("overflow_err", overflow_err, m_ovf);
      end
   end

   initial begin
      reset = 1'b0; valid_in = 1'b0; active_in = 1'b0; pop = 1'b0; data_in = '0;
      @(negedge clk_4f);
      rst_b();
      mon_en = 1'b1;
      rst_b();
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_empty", fifo_empty, 1'b1);

      // Basic in-order transfer
      push_b(8'h11); push_b(8'h22); push_b(8'h33);
      pop_b(); pop_b(); pop_b(); idle_b();
      chk("basic_empty_end", fifo_empty, 1'b1);

      // Fill, overflow, drain
      for (int i = 1; i <= 8; i++) push_b(DW'(i));
      chk("fill_full", fifo_full, 1'b1);
      push_b(8'h09);
      chk("ovf_set", overflow_err, 1'b1);
      for (int i = 0; i < 8; i++) pop_b();
      idle_b();

      // Simultaneous push/pop while full
      for (int i = 0; i < 8; i++) push_b(8'hC0 + DW'(i));
      both_b(8'hAA);
      chk("full_both_full", fifo_full, 1'b1);
      for (int i = 0; i < 8; i++) pop_b();
      idle_b();
      chk("aa_last", data_out, 8'hAA);

      // Simultaneous push/pop while empty: no fall-through
      both_b(8'h55);
      chk("empty_both_vld", valid_out, 1'b0);
      chk("empty_both_cnt1", fifo_empty, 1'b0);
      pop_b();
      chk("empty_both_data", data_out, 8'h55);
      idle_b();

      // Link not aligned blocks writes
      rst_b();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
      chk("inactive_empty", fifo_empty, 1'b1);
      chk("inactive_ovf", overflow_err, 1'b0);

      // Mid-operation reset discards contents
      for (int i = 0; i < 5; i++) push_b(8'h60 + DW'(i));
      pop_b();
      rst_b();
      chk("midrst_empty", fifo_empty, 1'b1);
      chk("midrst_vld", valid_out, 1'b0);
      pop_b();
      chk("midrst_pop_vld", valid_out, 1'b0);

      // Randomized traffic with phases biased toward filling or draining
      for (int blk = 0; blk < 12; blk++) begin
         for (int i = 0; i < 150; i++) begin
            logic rn, v, a, p;
            rn = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 9) != 0);
            p  = (blk % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc(rn, v, a, p, DW'($urandom));
         end
      end
      idle_b();
      idle_b();
      chk("sb_drained", sb.size(), 0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_fifo_buffer.md
RX_FIFO_BUFFER -- requirements
Module: rx_fifo_buffer

Interface
REQ-001 Parameter DATA_W, default 8: width of each stored byte.
REQ-002 Parameter DEPTH, default 8: number of FIFO entries; shall be a power of two.
REQ-003 Parameter AE_TH, default 2: almost_empty asserts when count <= AE_TH.
REQ-004 Parameter AF_TH, default 6: almost_full asserts when count >= AF_TH.
REQ-005 Clock and reset: the block has one clock, clk_4f; reset is synchronous and active-low.
REQ-006 clk_4f  input  1  parallel-byte clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 data_in  input  DATA_W  received parallel byte from the deserializer stage.
REQ-009 valid_in  input  1  data_in carries a payload byte this cycle (not 0xBC idle).
REQ-010 active_in  input  1  link aligned; gates all writes.
REQ-011 pop  input  1  consumer read request.
REQ-012 data_out  output  DATA_W  registered read data.
REQ-013 valid_out  output  1  data_out is valid this cycle.
REQ-014 fifo_empty, fifo_full  output  1 each  count==0, count==DEPTH.
REQ-015 almost_empty, almost_full  output  1 each  threshold flags per REQ-003/004.
REQ-016 overflow_err  output  1  sticky flag: a byte was dropped.

Function
REQ-017 A push shall be accepted when valid_in && active_in && (!fifo_full || pop_accepted).
REQ-018 A pop shall be accepted when pop && !fifo_empty; pop on empty is ignored, with no error.
REQ-019 Read latency shall be 1: data_out/valid_out update on the edge after the accepted pop; valid_out=0 on any cycle following a non-accepted pop.
REQ-020 data_out shall hold its last value when valid_out=0.
REQ-021 Write and read pointers shall be log2(DEPTH) bits and wrap modulo DEPTH without extra logic.
REQ-022 The occupancy counter shall be log2(DEPTH)+1 bits: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-023 Push and pop in the same cycle when empty: only the push is accepted (no fall-through); count becomes 1.
REQ-024 Push and pop in the same cycle when full: both are accepted; count stays DEPTH; the written byte lands in the freed slot.
REQ-025 A push attempt while full without an accepted pop shall drop the byte and set overflow_err, which stays at 1 until reset.
REQ-026 Deasserting active_in shall block writes only; stored bytes remain poppable; no flush.
REQ-027 All status flags shall be derived from the registered count and valid in the same cycle as the count.

Reset
REQ-028 When reset=0 at a rising edge: pointers=0, count=0, data_out=0, valid_out=0, overflow_err=0.
REQ-029 After reset: fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
REQ-030 Reset mid-operation shall discard all stored bytes; storage contents need not be cleared.
REQ-031 Push and pop shall both be ignored on any cycle in which reset=0.

Structure
REQ-032 A shared package shall hold DATA_W, DEPTH, the AE/AF defaults and the idle code constant 0xBC.
REQ-033 Storage shall be one sub-module, fifo_mem: DEPTH x DATA_W, one synchronous write port and one synchronous read port.
REQ-034 Pointer, count, flag and error logic shall reside in rx_fifo_buffer.

Verification
REQ-035 Reset, then push 0x11,0x22,0x33 with active_in=1, then pop three times -> data_out 0x11,0x22,0x33, each one cycle after its pop; fifo_empty=1 at the end.
REQ-036 Push 8 bytes 0x01..0x08 -> fifo_full=1 and almost_full from count 6; a 9th push 0x09 -> overflow_err=1; popping 8 times returns 0x01..0x08.
REQ-037 From full, pop and push 0xAA in the same cycle -> count stays 8; the eighth subsequent pop returns 0xAA.
REQ-038 From empty, push 0x55 and pop in the same cycle -> valid_out=0 next cycle, count=1; the next pop returns 0x55.
REQ-039 active_in=0 with valid_in=1, data 0x77, for 4 cycles -> count stays 0 and overflow_err=0.
REQ-040 Load 5 bytes, assert reset=0 for one cycle -> fifo_empty=1, valid_out=0, overflow_err=0; a following pop produces no valid_out.
